cla_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder built around a single shared 4-bit carry-lookahead slice.
- Operands are captured on a start pulse and fed through the slice one nibble per cycle, LSB nibble first.
- A registered carry is chained between nibbles, and a start/busy/done handshake is presented to the issuing logic.
- Used where a full-width CLA costs too much area and a latency of WIDTH/4 cycles is acceptable.

---
 rtl/cla_seq_pkg.sv | 20 ++
 rtl/cla4bit.sv | 35 +++
 rtl/cla_serial_adder.sv | 123 ++++++++++++
 tb/tb_cla_serial_adder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the serial carry-lookahead adder.
//   state_t  : controller state encoding (IDLE, RUN, DONE)
//   NIBBLE   : width of the shared lookahead slice
//   add_ovf  : two's-complement overflow from operand and result sign bits
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int NIBBLE = 4;

    // Overflow happens when both operands share a sign and the result sign differs.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla4bit.sv
// Combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a, b  in  4  nibble operands
//   cin   in  1  carry into bit 0
//   s     out 4  nibble sum
//   cout  out 1  carry out of bit 3
module cla4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Every carry is expanded from generate/propagate so no carry waits on another.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s    = w_p ^ w_c[3:0];
    assign cout = w_c[4];

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit lookahead slice, one
// nibble per cycle, LSB nibble first, with a registered inter-nibble carry.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        request, accepted in IDLE or DONE
//   a, b, cin    operands, sampled on the accepting edge
//   busy         high while nibbles are being processed
//   done         one-cycle pulse when sum/cout/ovf are valid
//   sum          result register, written nibble by nibble
//   cout, ovf    carry out and signed overflow, updated entering DONE
module cla_serial_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / NIBBLE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [3:0]       w_nib_s;
    logic             w_nib_c;

    // Nibble mux feeding the shared slice from the captured operands.
    assign w_nib_a = r_a[int'(r_idx)*NIBBLE +: NIBBLE];
    assign w_nib_b = r_b[int'(r_idx)*NIBBLE +: NIBBLE];

    cla4bit u_cla4bit (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .s    (w_nib_s),
        .cout (w_nib_c)
    );

    // Controller: operand capture, nibble sequencing and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= {IDX_W{1'b0}};
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= {IDX_W{1'b0}};
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_sum[int'(r_idx)*NIBBLE +: NIBBLE] <= w_nib_s;
                    r_carry <= w_nib_c;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        // The top nibble is being written on this edge, so its sign
                        // comes straight from the slice rather than from r_sum.
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cout  <= w_nib_c;
                        r_ovf   <= add_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_nib_s[3]);
                    end else begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed self-checking bench for cla_serial_adder (WIDTH=16 and WIDTH=4).
module tb_cla_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;
    logic        ovf4;

    int total;
    int bad;

    cla_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse on the 16-bit instance and wait (bounded) for done.
    // lat counts edges from the accepting edge to done; busy_cnt counts busy cycles.
    task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         output int lat, output int busy_cnt);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, sum, cout, ovf} !== 20'h0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", {busy, done, sum, cout, ovf}, 20'h0);
        end
        total++;
        if ({busy4, done4, sum4, cout4, ovf4} !== 8'h0) begin
            bad++;
            $display("FAIL reset_state_w4 got=%h exp=%h", {busy4, done4, sum4, cout4, ovf4}, 8'h0);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        do_op(16'h1234, 16'h4321, 1'b0, lat, bc);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        total++;
        if (bc !== 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
        total++;
        if ({busy, sum, cout, ovf} !== {1'b0, 16'h5555, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL basic_result got=%b_%h_%b_%b exp=0_5555_0_0", busy, sum, cout, ovf);
        end
        @(posedge clk); #1;
        total++;
        if ({done, busy, sum} !== {1'b0, 1'b0, 16'h5555}) begin
            bad++;
            $display("FAIL basic_hold got=%b_%b_%h exp=0_0_5555", done, busy, sum);
        end
        do_op(16'h00FF, 16'h0000, 1'b1, lat, bc);
        total++;
        if ({sum, cout, ovf} !== {16'h0100, 1'b0, 1'b0} || lat !== 4) begin
            bad++;
            $display("FAIL cin_add got=%h_%b_%b lat=%0d exp=0100_0_0 lat=4", sum, cout, ovf, lat);
        end
    endtask

    task automatic test_carry_ovf();
        int lat, bc;
        do_op(16'hFFFF, 16'h0001, 1'b0, lat, bc);
        total++;
        if ({sum, cout, ovf} !== {16'h0000, 1'b1, 1'b0} || lat !== 4) begin
            bad++;
            $display("FAIL ripple got=%h_%b_%b lat=%0d exp=0000_1_0 lat=4", sum, cout, ovf, lat);
        end
        do_op(16'h7FFF, 16'h0001, 1'b0, lat, bc);
        total++;
        if ({sum, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL pos_ovf got=%h_%b_%b exp=8000_0_1", sum, cout, ovf);
        end
        do_op(16'h8000, 16'h8000, 1'b0, lat, bc);
        total++;
        if ({sum, cout, ovf} !== {16'h0000, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL neg_ovf got=%h_%b_%b exp=0000_1_1", sum, cout, ovf);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        // Competing request while RUN, with different operands.
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        total++;
        if (sum !== 16'h3333 || lat !== 4) begin
            bad++;
            $display("FAIL start_in_run got=%h lat=%0d exp=3333 lat=4", sum, lat);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL start_in_run_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [15:0] ve [4];
        int lat;
        va[0] = 16'h1111; vb[0] = 16'h0001; ve[0] = 16'h1112;
        va[1] = 16'h0F0F; vb[1] = 16'h00F1; ve[1] = 16'h1000;
        va[2] = 16'h8000; vb[2] = 16'h7FFF; ve[2] = 16'hFFFF;
        va[3] = 16'hABCD; vb[3] = 16'h1111; ve[3] = 16'hBCDE;
        a = va[0]; b = vb[0]; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({busy, done} !== 2'b10) begin
                bad++;
                $display("FAIL b2b_accept[%0d] got=%b exp=10", i, {busy, done});
            end
            if (i < 3) begin a = va[i+1]; b = vb[i+1]; end
            else start = 1'b0;
            lat = 0;
            while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
            total++;
            if (sum !== ve[i] || lat !== 4) begin
                bad++;
                $display("FAIL b2b_result[%0d] got=%h lat=%0d exp=%h lat=4", i, sum, lat, ve[i]);
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, seen;
        do_op(16'hC000, 16'hB000, 1'b0, lat, bc);
        total++;
        if ({sum, cout, ovf} !== {16'h7000, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL prep got=%h_%b_%b exp=7000_1_1", sum, cout, ovf);
        end
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, cout, ovf} !== 20'h0) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=%h", {busy, done, sum, cout, ovf}, 20'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL no_done_after_reset got=%0d exp=0", seen); end
        do_op(16'h0001, 16'h0002, 1'b1, lat, bc);
        total++;
        if ({sum, cout, ovf} !== {16'h0004, 1'b0, 1'b0} || lat !== 4) begin
            bad++;
            $display("FAIL post_reset got=%h_%b_%b lat=%0d exp=0004_0_0 lat=4", sum, cout, ovf, lat);
        end
    endtask

    task automatic test_width4();
        int lat;
        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        total++;
        if ({busy4, done4} !== 2'b10) begin
            bad++;
            $display("FAIL w4_busy got=%b exp=10", {busy4, done4});
        end
        lat = 0;
        while (!done4 && lat < 20) begin @(posedge clk); #1; lat++; end
        total++;
        if ({sum4, cout4, ovf4} !== {4'h0, 1'b1, 1'b0} || lat !== 1) begin
            bad++;
            $display("FAIL w4_result got=%h_%b_%b lat=%0d exp=0_1_0 lat=1", sum4, cout4, ovf4, lat);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_carry_ovf();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
